// File: rtl/nn_pkg.sv
// Shared Q8.8 types, dimensions, sequencer state encoding and saturating
// arithmetic helpers for the forward/training sequencer.
package nn_pkg;

    typedef logic signed [15:0] q88_t;

    localparam int FRAC_BITS  = 8;
    localparam int KERNEL_DIM = 3;
    localparam int FC_N       = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_FWD_GO,
        S_FWD_WAIT,
        S_EVAL,
        S_TRN_GO,
        S_TRN_WAIT,
        S_COMMIT,
        S_FIN
    } seq_state_t;

    // Difference is formed in 17 bits so the overflow is visible before clamping.
    function automatic q88_t sat_sub16(input q88_t a, input q88_t b);
        logic signed [16:0] diff;
        diff = $signed({a[15], a}) - $signed({b[15], b});
        if (diff > 17'sd32767)
            return 16'sh7fff;
        else if (diff < -17'sd32768)
            return 16'sh8000;
        else
            return diff[15:0];
    endfunction

    function automatic q88_t sat_abs16(input q88_t a);
        if (a == 16'sh8000)
            return 16'sh7fff;
        else if (a < 16'sd0)
            return -a;
        else
            return a;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// Active weight bank (3x3 kernel, FC weights, FC bias) written only on an
// initial load or a trained-weight commit.
module weight_bank
    import nn_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load_init,
    input  logic                                        load_trained,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_init,
    input  logic [FC_N-1:0][15:0]                       fc_weights_init,
    input  logic [15:0]                                 fc_bias_init,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_trained,
    input  logic [FC_N-1:0][15:0]                       fc_weights_trained,
    input  logic [15:0]                                 fc_bias_trained,
    output logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_active,
    output logic [FC_N-1:0][15:0]                       fc_weights_active,
    output logic [15:0]                                 fc_bias_active
);

    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_active     <= '0;
            fc_weights_active <= '0;
            fc_bias_active    <= '0;
        end else if (load_init) begin
            kernel_active     <= kernel_init;
            fc_weights_active <= fc_weights_init;
            fc_bias_active    <= fc_bias_init;
        end else if (load_trained) begin
            kernel_active     <= kernel_trained;
            fc_weights_active <= fc_weights_trained;
            fc_bias_active    <= fc_bias_trained;
        end
    end

endmodule

// File: rtl/training_sequencer.sv
// Epoch sequencer driving the forward and training pipeline handshakes.
// Optional watchdog on the wait states is enabled with SEQ_TIMEOUT_EN.
module training_sequencer
    import nn_pkg::*;
#(
    parameter int                 EPOCH_W        = 8,
    parameter logic signed [15:0] ERR_TOL        = 16'sd8,
    parameter int                 TIMEOUT_CYCLES = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [EPOCH_W-1:0]                          num_epochs,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_init,
    input  logic [FC_N-1:0][15:0]                       fc_weights_init,
    input  logic [15:0]                                 fc_bias_init,
    input  logic [15:0]                                 label,
    output logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_active,
    output logic [FC_N-1:0][15:0]                       fc_weights_active,
    output logic [15:0]                                 fc_bias_active,
    output logic                                        fwd_start,
    input  logic                                        fwd_done,
    input  logic [15:0]                                 fwd_output,
    output logic                                        trn_start,
    input  logic                                        trn_done,
    input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][15:0] kernel_trained,
    input  logic [FC_N-1:0][15:0]                       fc_weights_trained,
    input  logic [15:0]                                 fc_bias_trained,
    output logic                                        busy,
    output logic                                        done,
    output logic [EPOCH_W-1:0]                          epoch_count,
`ifdef SEQ_TIMEOUT_EN
    output logic                                        timeout,
`endif
    output logic [15:0]                                 last_output,
    output logic [15:0]                                 last_error,
    output logic                                        converged
);

    seq_state_t         state;
    seq_state_t         next_state;
    logic [EPOCH_W-1:0] num_epochs_q;
    logic [15:0]        label_q;
    logic               load_init;
    logic               load_trained;
    logic               tol_hit;
    logic               epochs_reached;
    logic               timer_hit;

    weight_bank u_bank (
        .clk                (clk),
        .rst                (rst),
        .load_init          (load_init),
        .load_trained       (load_trained),
        .kernel_init        (kernel_init),
        .fc_weights_init    (fc_weights_init),
        .fc_bias_init       (fc_bias_init),
        .kernel_trained     (kernel_trained),
        .fc_weights_trained (fc_weights_trained),
        .fc_bias_trained    (fc_bias_trained),
        .kernel_active      (kernel_active),
        .fc_weights_active  (fc_weights_active),
        .fc_bias_active     (fc_bias_active)
    );

    always_comb begin
        tol_hit        = (ERR_TOL != 16'sd0) && (sat_abs16(last_error) <= ERR_TOL);
        epochs_reached = (epoch_count == num_epochs_q);
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer;

    // Leaving a wait state always passes through a non-wait state, so the
    // timer restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst || !(state == S_FWD_WAIT || state == S_TRN_WAIT))
            timer <= '0;
        else
            timer <= timer + TIMER_W'(1);
    end

    assign timer_hit = (timer == TIMER_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || state == S_LOAD)
            timeout <= 1'b0;
        else if ((state == S_FWD_WAIT && !fwd_done && timer_hit) ||
                 (state == S_TRN_WAIT && !trn_done && timer_hit))
            timeout <= 1'b1;
    end
`else
    assign timer_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // The pass after the last commit is the final one, so one forward pass
    // runs for every epoch plus one.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_LOAD;
            S_LOAD:     next_state = S_FWD_GO;
            S_FWD_GO:   next_state = S_FWD_WAIT;
            S_FWD_WAIT: begin
                if (fwd_done)       next_state = S_EVAL;
                else if (timer_hit) next_state = S_FIN;
            end
            S_EVAL: begin
                if (epochs_reached || tol_hit) next_state = S_FIN;
                else                           next_state = S_TRN_GO;
            end
            S_TRN_GO:   next_state = S_TRN_WAIT;
            S_TRN_WAIT: begin
                if (trn_done)       next_state = S_COMMIT;
                else if (timer_hit) next_state = S_FIN;
            end
            S_COMMIT:   next_state = S_FWD_GO;
            S_FIN:      next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        fwd_start    = (state == S_FWD_GO);
        trn_start    = (state == S_TRN_GO);
        done         = (state == S_FIN);
        busy         = (state != S_IDLE);
        load_init    = (state == S_LOAD);
        load_trained = (state == S_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_epochs_q <= '0;
            label_q      <= '0;
            epoch_count  <= '0;
            converged    <= 1'b0;
            last_output  <= '0;
            last_error   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    num_epochs_q <= num_epochs;
                    label_q      <= label;
                    epoch_count  <= '0;
                    converged    <= 1'b0;
                end
                S_FWD_WAIT: begin
                    if (fwd_done) begin
                        last_output <= fwd_output;
                        last_error  <= sat_sub16(label_q, fwd_output);
                    end
                end
                S_EVAL:   if (!epochs_reached && tol_hit) converged <= 1'b1;
                S_COMMIT: epoch_count <= epoch_count + EPOCH_W'(1);
                default: ;
            endcase
        end
    end

endmodule
